ps2_rx: RTL

PS/2 keyboard receiver that sits directly upstream of the SoC keyboard interface. It synchronises and filters the raw PS2_CLK and PS2_DATA pins and deframes 11-bit device-to-host frames. It folds the E0 (extended) and F0 (break) prefixes into flags and buffers complete scancodes in a small FIFO with a valid/ready handshake. It runs in the 10 MHz system clock domain.

---
 rtl/ps2_pkg.sv | 28 ++
 rtl/ps2_rx_if.sv | 13 +
 rtl/ps2_fifo.sv | 74 +++++++
 rtl/ps2_rx.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 receiver.
//   ps2_state_t : deframer FSM states
//   ps2_entry_t : one buffered scancode with its extended/break flags
//   PS2_BRK/PS2_EXT : prefix bytes folded into flags rather than buffered
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } ps2_state_t;

  localparam logic [7:0] PS2_BRK = 8'hF0;
  localparam logic [7:0] PS2_EXT = 8'hE0;

  typedef struct packed {
    logic       ext;
    logic       brk;
    logic [7:0] code;
  } ps2_entry_t;

  // PS/2 uses odd parity over the 8 data bits plus the parity bit.
  function automatic logic odd_parity_ok(input logic [7:0] b, input logic p);
    return ^{b, p};
  endfunction

endpackage

// File: rtl/ps2_rx_if.sv
// Scancode delivery handshake.
//   valid/code/brk/ext : head entry, driven by the producer (master)
//   ready              : consumer accepts head when valid & ready
interface ps2_rx_if;
  logic       valid;
  logic       ready;
  logic [7:0] code;
  logic       brk;
  logic       ext;

  modport master (output valid, output code, output brk, output ext, input ready);
  modport slave  (input valid, input code, input brk, input ext, output ready);
endinterface

// File: rtl/ps2_fifo.sv
// First-word-fall-through FIFO of ps2_entry_t.
//   clk, rst_n : clock, asynchronous active-low reset
//   push, din  : write request and data; ignored when full unless popping
//   full       : level == DEPTH
//   level      : occupancy
//   deq        : head entry and valid/ready handshake (pop on valid & ready)
module ps2_fifo
  import ps2_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  ps2_entry_t               din,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   level,
  ps2_rx_if.master                 deq
);

  localparam int unsigned AW = $clog2(DEPTH);

  ps2_entry_t    mem_q [DEPTH];
  ps2_entry_t    mem_d [DEPTH];
  logic [AW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [AW:0]   level_q, level_d;
  logic          pop, wr_en;

  assign full  = (level_q == (AW+1)'(DEPTH));
  assign level = level_q;
  assign pop   = deq.valid & deq.ready;
  // When full, a simultaneous pop frees the slot the write lands in; the
  // head read below still returns the old entry for this cycle.
  assign wr_en = push & (~full | pop);

  always_comb begin
    mem_d   = mem_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    level_d = level_q;
    if (wr_en) begin
      mem_d[wr_q] = din;
      wr_d        = wr_q + AW'(1);
    end
    if (pop) begin
      rd_d = rd_q + AW'(1);
    end
    if (wr_en && !pop) begin
      level_d = level_q + (AW+1)'(1);
    end else if (!wr_en && pop) begin
      level_d = level_q - (AW+1)'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      rd_q    <= '0;
      wr_q    <= '0;
      level_q <= '0;
    end else begin
      mem_q   <= mem_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      level_q <= level_d;
    end
  end

  assign deq.valid = (level_q != '0);
  assign deq.code  = mem_q[rd_q].code;
  assign deq.brk   = mem_q[rd_q].brk;
  assign deq.ext   = mem_q[rd_q].ext;

endmodule

// File: rtl/ps2_rx.sv
// PS/2 keyboard receiver: pin synchronisers, clock glitch filter, 11-bit
// frame deframer with timeout, E0/F0 prefix folding and a scancode FIFO.
//   i_clk, i_rst_n        : 10 MHz system clock, async active-low reset
//   i_ps2_clk, i_ps2_data : raw asynchronous PS/2 pins
//   o_valid, i_ready      : FIFO head handshake
//   o_code, o_brk, o_ext  : head scancode and release/extended flags
//   o_level               : FIFO occupancy
//   o_frame_err           : one-cycle pulse on bad frame or timeout
//   o_overrun             : sticky, a decoded code was dropped (FIFO full)
module ps2_rx
  import ps2_pkg::*;
#(
  parameter int unsigned FILT    = 4,
  parameter int unsigned TIMEOUT = 20000,
  parameter int unsigned DEPTH   = 4
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_ps2_clk,
  input  logic                     i_ps2_data,
  output logic                     o_valid,
  input  logic                     i_ready,
  output logic [7:0]               o_code,
  output logic                     o_brk,
  output logic                     o_ext,
  output logic [$clog2(DEPTH):0]   o_level,
  output logic                     o_frame_err,
  output logic                     o_overrun
);

  localparam int unsigned FW = $clog2(FILT + 1);
  localparam int unsigned TW = $clog2(TIMEOUT);

  // Synchronisers
  logic clk_s1_q, clk_s2_q, dat_s1_q, dat_s2_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      clk_s1_q <= 1'b1;
      clk_s2_q <= 1'b1;
      dat_s1_q <= 1'b1;
      dat_s2_q <= 1'b1;
    end else begin
      clk_s1_q <= i_ps2_clk;
      clk_s2_q <= clk_s1_q;
      dat_s1_q <= i_ps2_data;
      dat_s2_q <= dat_s1_q;
    end
  end

  // Glitch filter on the PS/2 clock
  logic          filt_q, filt_d;
  logic [FW-1:0] fcnt_q, fcnt_d;
  logic          fall;

  always_comb begin
    filt_d = filt_q;
    fcnt_d = '0;
    if (clk_s2_q != filt_q) begin
      if (fcnt_q == FW'(FILT - 1)) filt_d = clk_s2_q;
      else                         fcnt_d = fcnt_q + FW'(1);
    end
  end

  assign fall = filt_q & ~filt_d;

  // Deframer
  ps2_state_t    state_q, state_d;
  logic [7:0]    shift_q, shift_d;
  logic [2:0]    bitcnt_q, bitcnt_d;
  logic          par_q, par_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          tmo_expire;
  logic          err_q, err_d;
  logic          brk_pend_q, brk_pend_d;
  logic          ext_pend_q, ext_pend_d;
  logic          overrun_q, overrun_d;
  logic          good, push;
  ps2_entry_t    entry;
  logic          fifo_full;

  ps2_rx_if q_if ();

  // A fall edge always wins over an expiring timeout in the same cycle.
  assign tmo_expire = (state_q != IDLE) && !fall && (tmo_q == TW'(TIMEOUT - 1));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (fall) begin
      unique case (state_q)
        IDLE:    if (!dat_s2_q) state_d = DATA;
        DATA:    if (bitcnt_q == 3'd7) state_d = PARITY;
        PARITY:  state_d = STOP;
        STOP:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end else if (tmo_expire) begin
      state_d = IDLE;
    end
  end

  always_comb begin
    shift_d    = shift_q;
    bitcnt_d   = bitcnt_q;
    par_d      = par_q;
    tmo_d      = '0;
    brk_pend_d = brk_pend_q;
    ext_pend_d = ext_pend_q;
    push       = 1'b0;
    entry      = '{ext: ext_pend_q, brk: brk_pend_q, code: shift_q};

    if (state_q != IDLE && !fall && !tmo_expire) tmo_d = tmo_q + TW'(1);

    good  = fall && (state_q == STOP) && dat_s2_q && odd_parity_ok(shift_q, par_q);
    err_d = (fall && (state_q == STOP) && !good) || tmo_expire;

    if (fall) begin
      unique case (state_q)
        IDLE:    bitcnt_d = '0;
        DATA: begin
          shift_d  = {dat_s2_q, shift_q[7:1]};
          bitcnt_d = bitcnt_q + 3'd1;
        end
        PARITY:  par_d = dat_s2_q;
        default: ;
      endcase
    end

    if (good) begin
      if (shift_q == PS2_BRK) begin
        brk_pend_d = 1'b1;
      end else if (shift_q == PS2_EXT) begin
        ext_pend_d = 1'b1;
      end else begin
        push       = 1'b1;
        brk_pend_d = 1'b0;
        ext_pend_d = 1'b0;
      end
    end

    overrun_d = overrun_q | (push & fifo_full & ~(q_if.valid & q_if.ready));
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      filt_q     <= 1'b1;
      fcnt_q     <= '0;
      shift_q    <= '0;
      bitcnt_q   <= '0;
      par_q      <= 1'b0;
      tmo_q      <= '0;
      err_q      <= 1'b0;
      brk_pend_q <= 1'b0;
      ext_pend_q <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      filt_q     <= filt_d;
      fcnt_q     <= fcnt_d;
      shift_q    <= shift_d;
      bitcnt_q   <= bitcnt_d;
      par_q      <= par_d;
      tmo_q      <= tmo_d;
      err_q      <= err_d;
      brk_pend_q <= brk_pend_d;
      ext_pend_q <= ext_pend_d;
      overrun_q  <= overrun_d;
    end
  end

  // Scancode FIFO
  assign q_if.ready = i_ready;

  ps2_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (i_clk),
    .rst_n (i_rst_n),
    .push  (push),
    .din   (entry),
    .full  (fifo_full),
    .level (o_level),
    .deq   (q_if.master)
  );

  assign o_valid     = q_if.valid;
  assign o_code      = q_if.code;
  assign o_brk       = q_if.brk;
  assign o_ext       = q_if.ext;
  assign o_frame_err = err_q;
  assign o_overrun   = overrun_q;

endmodule
